bellek_erisim_birimi: RTL
=========================

Name: bellek_erisim_birimi

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address, plus the store data and access size from the execute stage.
- Runs one transaction on a valid/ready data-memory port and stalls the pipeline while it is busy.
- Returns an aligned, sign- or zero-extended load value, or a fault flag, to writeback.

Parameters:
- ZAMAN_ASIMI, 255, cycles in ISTEK without bellek_hazir_g before the bus-error fault is raised (legal range 1..65535).

Ports:
- clk_g  input  1  clock
- rst_g  input  1  reset; asynchronous, active-high
- istek_gecerli_g  input  1  load/store request present; held stable while durdur_c=1
- yaz_g  input  1  1=store, 0=load
- boyut_g  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal
- isaretsiz_g  input  1  load zero-extends (LBU/LHU); ignored for stores and words
- adres_g  input  32  effective address (ALU sonuc)
- veri_g  input  32  store data (rs2)
- durdur_c  output  1  pipeline stall
- sonuc_gecerli_c  output  1  one-cycle completion strobe
- sonuc_c  output  32  load data; 0 for stores and faults
- hizasiz_c  output  1  misaligned or illegal-size fault, qualified by sonuc_gecerli_c
- hata_c  output  1  bus timeout fault, qualified by sonuc_gecerli_c
- bellek_gecerli_c  output  1  memory request valid
- bellek_yaz_c  output  1  memory write
- bellek_adres_c  output  32  word address, {adres_g[31:2],2'b00}
- bellek_veri_c  output  32  write data, lane-replicated
- bellek_maske_c  output  4  byte enables
- bellek_hazir_g  input  1  memory accepts/completes in this cycle
- bellek_veri_g  input  32  read word, valid when bellek_hazir_g=1

Behaviour:
- Reset (async, rst_g=1): state BOSTA, counter 0, every output 0. Reset during ISTEK drops bellek_gecerli_c immediately; no completion is produced.
- durdur_c is combinational: (BOSTA & istek_gecerli_g) | ISTEK. It is 0 in YANIT, so the upstream stage retires the held instruction on that edge.
- FSM states BOSTA, ISTEK, YANIT:
  - BOSTA, istek_gecerli_g=1, fault-free: latch all request fields; go to ISTEK.
  - BOSTA, faulting request: go to YANIT with hizasiz_c=1; no bus access. A fault is boyut 11, half with adres[0]=1, or word with adres[1:0]!=0.
  - ISTEK: bellek_gecerli_c=1, all bus outputs registered and stable.
    - bellek_hazir_g=1: capture the extended read data; go to YANIT.
    - Otherwise the counter increments. At counter==ZAMAN_ASIMI-1 with no hazir: go to YANIT with hata_c=1, sonuc_c=0.
    - hazir in the timeout cycle wins: normal completion, no hata_c.
  - YANIT: sonuc_gecerli_c=1 for exactly one cycle; istek_gecerli_g is ignored (it is the retiring request); counter cleared; go to BOSTA.
- Minimum occupancy is 3 cycles: request at T, bellek_gecerli_c at T+1, sonuc_gecerli_c at T+2 with zero wait states. Back-to-back requests start at T+3.
- Store byte enables (o=adres[1:0]):
  - SB: 1<<o.
  - SH: 0011 if o=00, else 1100.
  - SW: 1111.
- Store write data: bellek_veri_c = {4{veri[7:0]}} for SB, {2{veri[15:0]}} for SH, veri for SW.
- Loads: bellek_yaz_c=0; bellek_maske_c uses the same lane pattern as stores.
- Load extraction:
  - Byte = bellek_veri_g[8*o+7:8*o].
  - Half = bellek_veri_g[16*o[1]+15:16*o[1]].
  - Sign-extended unless isaretsiz_g=1.
- Outside YANIT: sonuc_c, hizasiz_c and hata_c are 0.

Test Plan:
- LW adres=0x1000, hazir at first ISTEK cycle, bellek_veri_g=0xDEADBEEF -> bellek_adres_c=0x1000, maske=1111, sonuc_c=0xDEADBEEF; sonuc_gecerli_c at T+2; durdur_c high at T and T+1 only.
- LB adres=0x1003 with word 0x80FF_1234 -> sonuc_c=0xFFFFFF80. Same access as LBU -> 0x00000080. LH adres=0x1002 -> 0xFFFF80FF.
- SB adres=0x2001, veri=0x000000A5, hazir after 3 wait cycles -> bellek_veri_c=0xA5A5A5A5, maske=0010, yaz=1 held stable 4 cycles; sonuc_c=0.
- SW adres=0x2002 -> no bellek_gecerli_c; next cycle sonuc_gecerli_c=1, hizasiz_c=1. Also boyut=11 -> hizasiz_c=1.
- ZAMAN_ASIMI=4, hazir never asserted -> bellek_gecerli_c for 4 cycles, then hata_c=1 with sonuc_gecerli_c. Repeat with hazir in the 4th cycle -> normal completion, hata_c=0.
- rst_g pulsed during the 2nd ISTEK cycle -> bellek_gecerli_c falls without waiting for a clock edge; no sonuc_gecerli_c; a new request after reset completes normally.

Source files
------------

// File: rtl/bellek_erisim_birimi_if.sv
// Data-memory port of the load/store unit.
//   master: drives request (gecerli, yaz, adres, veri, maske), observes hazir and read data.
//   slave : the memory side, drives bellek_hazir_g and bellek_veri_g.
// bellek_veri_g is only meaningful in a cycle where bellek_hazir_g=1.
interface bellek_erisim_birimi_if;
  logic        bellek_gecerli_c;
  logic        bellek_yaz_c;
  logic [31:0] bellek_adres_c;
  logic [31:0] bellek_veri_c;
  logic [3:0]  bellek_maske_c;
  logic        bellek_hazir_g;
  logic [31:0] bellek_veri_g;

  modport master (
    output bellek_gecerli_c,
    output bellek_yaz_c,
    output bellek_adres_c,
    output bellek_veri_c,
    output bellek_maske_c,
    input  bellek_hazir_g,
    input  bellek_veri_g
  );

  modport slave (
    input  bellek_gecerli_c,
    input  bellek_yaz_c,
    input  bellek_adres_c,
    input  bellek_veri_c,
    input  bellek_maske_c,
    output bellek_hazir_g,
    output bellek_veri_g
  );
endinterface

// File: rtl/bellek_erisim_birimi.sv
// Load/store unit sitting after the ALU. Accepts one load/store per request, runs it on a
// valid/ready data-memory port and stalls the pipeline until the result is ready.
//
// Ports:
//   clk_g, rst_g           clock, asynchronous active-high reset
//   istek_gecerli_g        request present (held stable while durdur_c=1)
//   yaz_g, boyut_g         store/load select, access size (00 B, 01 H, 10 W, 11 illegal)
//   isaretsiz_g            zero-extend loads (LBU/LHU)
//   adres_g, veri_g        effective address, store data
//   durdur_c               pipeline stall
//   sonuc_gecerli_c        one-cycle completion strobe
//   sonuc_c                extended load data (0 for stores and faults)
//   hizasiz_c, hata_c      misaligned/illegal-size fault, bus timeout fault
//   bellek                 data-memory port (master side)
module bellek_erisim_birimi #(
  parameter int unsigned ZAMAN_ASIMI = 255
) (
  input  logic                          clk_g,
  input  logic                          rst_g,
  input  logic                          istek_gecerli_g,
  input  logic                          yaz_g,
  input  logic [1:0]                    boyut_g,
  input  logic                          isaretsiz_g,
  input  logic [31:0]                   adres_g,
  input  logic [31:0]                   veri_g,
  output logic                          durdur_c,
  output logic                          sonuc_gecerli_c,
  output logic [31:0]                   sonuc_c,
  output logic                          hizasiz_c,
  output logic                          hata_c,
  bellek_erisim_birimi_if.master        bellek
);

  localparam logic [15:0] SayacSon = 16'(ZAMAN_ASIMI - 1);

  typedef enum logic [1:0] {
    StBosta = 2'd0,
    StIstek = 2'd1,
    StYanit = 2'd2
  } durum_e;

  durum_e      durum_q, durum_d;
  logic [15:0] sayac_q, sayac_d;

  // Latched request fields, loaded on acceptance in StBosta.
  logic        yaz_q;
  logic [1:0]  boyut_q;
  logic        isaretsiz_q;
  logic [1:0]  ofset_q;
  logic [31:0] adres_q;
  logic [31:0] veri_q;
  logic [3:0]  maske_q;

  // Result registers, presented only in StYanit.
  logic [31:0] sonuc_q, sonuc_d;
  logic        hizasiz_q, hizasiz_d;
  logic        hata_q, hata_d;

  logic        yakala;
  logic        hizasiz_istek;
  logic [3:0]  maske_hesap;
  logic [31:0] veri_hesap;
  logic [31:0] yukle_veri;

  // Alignment check and lane steering for the incoming request.
  always_comb begin
    hizasiz_istek = 1'b0;
    maske_hesap   = 4'b0000;
    veri_hesap    = 32'h0;
    unique case (boyut_g)
      2'b00: begin
        maske_hesap = 4'b0001 << adres_g[1:0];
        veri_hesap  = {4{veri_g[7:0]}};
      end
      2'b01: begin
        hizasiz_istek = adres_g[0];
        maske_hesap   = (adres_g[1:0] == 2'b00) ? 4'b0011 : 4'b1100;
        veri_hesap    = {2{veri_g[15:0]}};
      end
      2'b10: begin
        hizasiz_istek = (adres_g[1:0] != 2'b00);
        maske_hesap   = 4'b1111;
        veri_hesap    = veri_g;
      end
      default: begin
        hizasiz_istek = 1'b1;
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    logic [7:0]  bayt;
    logic [15:0] yarim;
    bayt       = bellek.bellek_veri_g[8*ofset_q +: 8];
    yarim      = bellek.bellek_veri_g[16*ofset_q[1] +: 16];
    yukle_veri = bellek.bellek_veri_g;
    unique case (boyut_q)
      2'b00:   yukle_veri = isaretsiz_q ? {24'h0, bayt} : {{24{bayt[7]}}, bayt};
      2'b01:   yukle_veri = isaretsiz_q ? {16'h0, yarim} : {{16{yarim[15]}}, yarim};
      default: yukle_veri = bellek.bellek_veri_g;
    endcase
  end

  // Next-state logic.
  always_comb begin
    durum_d   = durum_q;
    sayac_d   = sayac_q;
    sonuc_d   = sonuc_q;
    hizasiz_d = hizasiz_q;
    hata_d    = hata_q;
    yakala    = 1'b0;
    unique case (durum_q)
      StBosta: begin
        if (istek_gecerli_g) begin
          sonuc_d = 32'h0;
          hata_d  = 1'b0;
          sayac_d = 16'h0;
          if (hizasiz_istek) begin
            // Faulting requests never touch the bus.
            hizasiz_d = 1'b1;
            durum_d   = StYanit;
          end else begin
            hizasiz_d = 1'b0;
            yakala    = 1'b1;
            durum_d   = StIstek;
          end
        end
      end
      StIstek: begin
        if (bellek.bellek_hazir_g) begin
          // A ready in the timeout cycle still completes normally.
          sonuc_d = yaz_q ? 32'h0 : yukle_veri;
          durum_d = StYanit;
        end else if (sayac_q == SayacSon) begin
          hata_d  = 1'b1;
          sonuc_d = 32'h0;
          durum_d = StYanit;
        end else begin
          sayac_d = sayac_q + 16'd1;
        end
      end
      StYanit: begin
        // The request still on istek_gecerli_g is the one retiring now.
        sayac_d   = 16'h0;
        sonuc_d   = 32'h0;
        hizasiz_d = 1'b0;
        hata_d    = 1'b0;
        durum_d   = StBosta;
      end
      default: begin
        durum_d = StBosta;
      end
    endcase
  end

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      durum_q   <= StBosta;
      sayac_q   <= 16'h0;
      sonuc_q   <= 32'h0;
      hizasiz_q <= 1'b0;
      hata_q    <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      sayac_q   <= sayac_d;
      sonuc_q   <= sonuc_d;
      hizasiz_q <= hizasiz_d;
      hata_q    <= hata_d;
    end
  end

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      yaz_q       <= 1'b0;
      boyut_q     <= 2'b00;
      isaretsiz_q <= 1'b0;
      ofset_q     <= 2'b00;
      adres_q     <= 32'h0;
      veri_q      <= 32'h0;
      maske_q     <= 4'b0000;
    end else if (yakala) begin
      yaz_q       <= yaz_g;
      boyut_q     <= boyut_g;
      isaretsiz_q <= isaretsiz_g;
      ofset_q     <= adres_g[1:0];
      adres_q     <= {adres_g[31:2], 2'b00};
      veri_q      <= veri_hesap;
      maske_q     <= maske_hesap;
    end
  end

  // Bus outputs come straight from registers; gating by state keeps them 0 outside the access.
  always_comb begin
    logic istekte;
    istekte                 = (durum_q == StIstek);
    bellek.bellek_gecerli_c = istekte;
    bellek.bellek_yaz_c     = istekte & yaz_q;
    bellek.bellek_adres_c   = istekte ? adres_q : 32'h0;
    bellek.bellek_veri_c    = istekte ? veri_q : 32'h0;
    bellek.bellek_maske_c   = istekte ? maske_q : 4'b0000;
  end

  always_comb begin
    logic yanitta;
    yanitta         = (durum_q == StYanit);
    durdur_c        = ((durum_q == StBosta) & istek_gecerli_g) | (durum_q == StIstek);
    sonuc_gecerli_c = yanitta;
    sonuc_c         = yanitta ? sonuc_q : 32'h0;
    hizasiz_c       = yanitta & hizasiz_q;
    hata_c          = yanitta & hata_q;
  end

endmodule
